// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// The optional return-address stack is enabled by the PC_SEQ_RAS_EN macro.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;
  localparam int          RAS_DEPTH     = 4;

  // Instruction fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_seq_ras.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
// A simultaneous pop and push replaces the top entry in place.
module pc_seq_ras
  import pc_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_top,
  output logic              o_empty
);

  localparam int                PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);

  logic [DATA_W-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [PTR_W:0]    r_cnt;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_pop_ok;

  assign w_top_idx = r_sp - 1'b1;
  assign w_pop_ok  = i_pop & (r_cnt != '0);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (w_pop_ok && !i_push) begin
      r_sp  <= r_sp - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end else if (i_push && !w_pop_ok) begin
      r_sp <= r_sp + 1'b1;
      if (r_cnt != CNT_FULL) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_pop_ok ? w_top_idx : r_sp] <= i_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/TRAP/HALT FSM with prioritised redirects and exception entry.
// Define PC_SEQ_RAS_EN to compile in the return-address stack for call/return prediction.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        call_i,
  input  logic        ret_i,
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic [31:0] epc_o,
  output logic [1:0]  state_o
);

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_pc_valid;

  logic        w_accept;
  logic        w_take_jr;
  logic [31:0] w_pc_inc;
  logic [31:0] w_jr_dest;
  logic [31:0] w_pc_next;

  // A redirect is only accepted while running and nothing higher (exception, halt, stall) wins.
  assign w_accept  = (r_state == ST_RUN) & ~exc_i & ~halt_i & ~stall_i;
  assign w_take_jr = w_accept & ~eret_i & jr_i;
  assign w_pc_inc  = word_align(r_pc + 32'd4);

`ifdef PC_SEQ_RAS_EN
  logic        w_ras_push;
  logic        w_ras_pop;
  logic [31:0] w_ras_top;
  logic        w_ras_empty;

  assign w_ras_push = w_accept & call_i;
  assign w_ras_pop  = w_take_jr & ret_i;

  pc_seq_ras #(.DATA_W(32)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ras_push),
    .i_pop   (w_ras_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty)
  );

  assign w_jr_dest = (w_ras_pop && !w_ras_empty) ? w_ras_top : jr_target_i;
`else
  logic w_unused_link;
  assign w_unused_link = call_i ^ ret_i;
  assign w_jr_dest     = jr_target_i;
`endif

  always_comb begin
    w_pc_next = w_pc_inc;
    if (eret_i)          w_pc_next = r_epc;
    else if (w_take_jr)  w_pc_next = word_align(w_jr_dest);
    else if (jmp_i)      w_pc_next = word_align(jmp_target_i);
    else if (br_taken_i) w_pc_next = word_align(br_target_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VEC;
      r_epc      <= '0;
      r_pc_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT, ST_TRAP: begin
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (exc_i) begin
            r_epc      <= r_pc;
            r_pc       <= EXC_VEC;
            r_state    <= ST_TRAP;
            r_pc_valid <= 1'b0;
          end else if (halt_i) begin
            r_state    <= ST_HALT;
            r_pc_valid <= 1'b0;
          end else if (w_accept) begin
            r_pc <= w_pc_next;
          end
        end
        ST_HALT: begin
          if (exc_i) begin
            r_epc      <= r_pc;
            r_pc       <= EXC_VEC;
            r_state    <= ST_TRAP;
            r_pc_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = r_pc_valid;
  assign epc_o      = r_epc;
  assign state_o    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus randomized traffic against a reference model.
// The model's return-address stack follows the PC_SEQ_RAS_EN macro, like the design.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0180;
  localparam logic [31:0] ALIGN     = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, br_taken_i, jmp_i, jr_i, call_i, ret_i, exc_i, eret_i, halt_i;
  logic [31:0] br_target_i, jmp_target_i, jr_target_i;
  logic [31:0] pc_o, epc_o;
  logic        pc_valid_o;
  logic [1:0]  state_o;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .jr_i         (jr_i),
    .jr_target_i  (jr_target_i),
    .call_i       (call_i),
    .ret_i        (ret_i),
    .exc_i        (exc_i),
    .eret_i       (eret_i),
    .halt_i       (halt_i),
    .pc_o         (pc_o),
    .pc_valid_o   (pc_valid_o),
    .epc_o        (epc_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic [31:0] epc;
    logic [1:0]  st;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: states 0=BOOT 1=RUN 2=TRAP 3=HALT
  logic [31:0] m_pc, m_epc;
  int          m_st;
  logic [31:0] m_ras[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.pc  = m_pc;
    e.vld = (m_st == 1);
    e.epc = m_epc;
    e.st  = 2'(m_st);
    return e;
  endfunction

  function automatic void model_reset();
    m_pc  = RESET_VEC;
    m_epc = 32'h0;
    m_st  = 0;
    m_ras.delete();
  endfunction

  function automatic void model_edge();
    logic [31:0] nxt, jr_t, link;
    if (m_st == 0 || m_st == 2) begin
      m_st = 1;
    end else if (exc_i) begin
      m_epc = m_pc;
      m_pc  = EXC_VEC;
      m_st  = 2;
    end else if (m_st == 1 && halt_i) begin
      m_st = 3;
    end else if (m_st == 1 && !stall_i) begin
      link = (m_pc + 32'd4) & ALIGN;
      jr_t = jr_target_i;
`ifdef PC_SEQ_RAS_EN
      if (jr_i && !eret_i && ret_i && m_ras.size() > 0) jr_t = m_ras.pop_back();
      if (call_i) begin
        m_ras.push_back(link);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
`endif
      if (eret_i)          nxt = m_epc;
      else if (jr_i)       nxt = jr_t & ALIGN;
      else if (jmp_i)      nxt = jmp_target_i & ALIGN;
      else if (br_taken_i) nxt = br_target_i & ALIGN;
      else                 nxt = link;
      m_pc = nxt;
    end
  endfunction

  task automatic clear_inputs();
    {stall_i, br_taken_i, jmp_i, jr_i, call_i, ret_i, exc_i, eret_i, halt_i} = '0;
    br_target_i = '0; jmp_target_i = '0; jr_target_i = '0;
  endtask

  // Called 2 time units after a rising edge with inputs set for the next edge.
  task automatic tick();
    model_edge();
    q.push_back(model_now());
    @(posedge clk);
    #2;
    clear_inputs();
  endtask

  task automatic do_reset();
    exp_t e;
    #4;
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    e = model_now();
    cmp("async_rst_pc", pc_o, e.pc);
    cmp("async_rst_state", {30'b0, state_o}, {30'b0, e.st});
    cmp("async_rst_valid", {31'b0, pc_valid_o}, {31'b0, e.vld});
    cmp("async_rst_epc", epc_o, e.epc);
    q.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.push_back(model_now());
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("pc", pc_o, e.pc);
      cmp("pc_valid", {31'b0, pc_valid_o}, {31'b0, e.vld});
      cmp("epc", epc_o, e.epc);
      cmp("state", {30'b0, state_o}, {30'b0, e.st});
    end
  end

  task automatic jump_to(input logic [31:0] t);
    jmp_i = 1'b1; jmp_target_i = t;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #2;
    do_reset();

    // Free-running fetch after reset release
    tick(); tick(); tick();

    // Branch with and without stall
    jump_to(32'h40);
    br_taken_i = 1'b1; br_target_i = 32'h103; stall_i = 1'b1; tick();
    br_taken_i = 1'b1; br_target_i = 32'h103; tick();

    // Exception beats stall and jump; bubble; eret
    jump_to(32'h80);
    exc_i = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h500; stall_i = 1'b1; tick();
    jmp_i = 1'b1; jmp_target_i = 32'h700; exc_i = 1'b1; tick();
    tick(); tick();
    eret_i = 1'b1; jr_i = 1'b1; jr_target_i = 32'h300; tick();

    // Wrap at top of address space
    jump_to(32'hFFFF_FFFC);
    tick();

    // Halt, exception out of halt, reset mid-trap
    jump_to(32'h20);
    halt_i = 1'b1; tick();
    jmp_i = 1'b1; jmp_target_i = 32'h44; tick();
    exc_i = 1'b1; tick();
    do_reset();
    tick();

    // Call / return; five calls then five returns
    jump_to(32'h10);
    call_i = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h200; tick();
    jr_i = 1'b1; ret_i = 1'b1; jr_target_i = 32'h999; tick();
    for (int k = 1; k <= 5; k++) begin
      call_i = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h1000 * k; tick();
    end
    for (int k = 0; k < 5; k++) begin
      jr_i = 1'b1; ret_i = 1'b1; jr_target_i = 32'h999; tick();
    end
    call_i = 1'b1; jr_i = 1'b1; ret_i = 1'b1; jr_target_i = 32'h2222; tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        exc_i        = ($urandom_range(0, 15) == 0);
        halt_i       = ($urandom_range(0, 31) == 0);
        stall_i      = ($urandom_range(0, 3) == 0);
        eret_i       = ($urandom_range(0, 7) == 0);
        jr_i         = ($urandom_range(0, 5) == 0);
        ret_i        = ($urandom_range(0, 1) == 0);
        call_i       = ($urandom_range(0, 3) == 0);
        jmp_i        = ($urandom_range(0, 5) == 0);
        br_taken_i   = ($urandom_range(0, 3) == 0);
        br_target_i  = $urandom;
        jmp_target_i = $urandom;
        jr_target_i  = $urandom;
        tick();
      end
    end

    #10;
    cmp("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
